// File: rtl/edge_freq_counter.sv
// Gated pulse counter: counts pulse_i over a programmable window of clock edges.
// The saturating result is held with valid_o until the consumer acknowledges it.
module edge_freq_counter #(
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned GATE_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pulse_i,
    input  logic [GATE_WIDTH-1:0] gate_len_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  ack_i,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  overflow_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

    state_e                state_q;
    logic [GATE_WIDTH-1:0] remain_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  ovf_q;

    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  ovf_next;

    // Saturating increment; an increment attempted at all-ones latches overflow.
    always_comb begin
        cnt_next = cnt_q;
        ovf_next = ovf_q;
        if (pulse_i) begin
            if (&cnt_q) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            remain_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            count_o    <= '0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        cnt_q  <= '0;
                        ovf_q  <= 1'b0;
                        busy_o <= 1'b1;
                        if (gate_len_i == '0) begin
                            state_q    <= StDone;
                            count_o    <= '0;
                            overflow_o <= 1'b0;
                            valid_o    <= 1'b1;
                        end else begin
                            state_q  <= StCount;
                            remain_q <= gate_len_i;
                        end
                    end
                end
                StCount: begin
                    if (abort_i) begin
                        state_q <= StIdle;
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_next;
                        ovf_q <= ovf_next;
                        // remain_q == 1 marks the last edge of the window, whose pulse counts.
                        if (remain_q == GATE_WIDTH'(1)) begin
                            state_q    <= StDone;
                            remain_q   <= '0;
                            count_o    <= cnt_next;
                            overflow_o <= ovf_next;
                            valid_o    <= 1'b1;
                        end else begin
                            remain_q <= remain_q - GATE_WIDTH'(1);
                        end
                    end
                end
                StDone: begin
                    if (abort_i || ack_i) begin
                        state_q <= StIdle;
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_freq_counter.sv
// Bench for edge_freq_counter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a window-arithmetic model.
module tb_edge_freq_counter;

    localparam int CW   = 4;
    localparam int GW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          pulse_i;
    logic [GW-1:0] gate_len_i;
    logic          start_i;
    logic          abort_i;
    logic          ack_i;
    logic [CW-1:0] count_o;
    logic          overflow_o;
    logic          valid_o;
    logic          busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    edge_freq_counter #(
        .CNT_WIDTH  (CW),
        .GATE_WIDTH (GW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pulse_i    (pulse_i),
        .gate_len_i (gate_len_i),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .ack_i      (ack_i),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o)
    );

    // Model: a window opened at edge cycle t0 with length N closes at edge t0+N;
    // the result is the number of pulses seen on edges t0+1..t0+N, clipped to MAXC.
    int            cyc        = 0;
    int            win_end    = 0;
    int            raw        = 0;
    bit            in_window  = 0;
    bit            holding    = 0;
    bit            seen_reset = 0;
    logic [CW-1:0] m_count    = '0;
    bit            m_ovf      = 0;
    bit            m_valid    = 0;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            in_window  = 0;
            holding    = 0;
            raw        = 0;
            m_count    = '0;
            m_ovf      = 0;
            m_valid    = 0;
            seen_reset = 1;
        end else if (in_window) begin
            if (abort_i) begin
                in_window = 0;
                m_valid   = 0;
            end else begin
                if (pulse_i) raw++;
                if (cyc == win_end) begin
                    in_window = 0;
                    holding   = 1;
                    m_valid   = 1;
                    m_count   = CW'((raw > MAXC) ? MAXC : raw);
                    m_ovf     = (raw > MAXC);
                end
            end
        end else if (holding) begin
            if (abort_i || ack_i) begin
                holding = 0;
                m_valid = 0;
            end
        end else if (start_i) begin
            if (gate_len_i == 0) begin
                holding = 1;
                m_valid = 1;
                m_count = '0;
                m_ovf   = 0;
            end else begin
                in_window = 1;
                raw       = 0;
                win_end   = cyc + int'(gate_len_i);
            end
        end
        #1;
        if (seen_reset) begin
            n_tests++;
            if ({count_o, overflow_o, valid_o, busy_o} !==
                {m_count, m_ovf, m_valid, (in_window || holding)}) begin
                n_fail++;
                $display("FAIL model cyc=%0d: got count=%0d ovf=%b valid=%b busy=%b, expected count=%0d ovf=%b valid=%b busy=%b",
                         cyc, count_o, overflow_o, valid_o, busy_o,
                         m_count, m_ovf, m_valid, (in_window || holding));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        pulse_i    = 1'b0;
        gate_len_i = '0;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        ack_i      = 1'b0;
    endtask

    task automatic do_ack();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("reset_count", 32'(count_o), 0);
        check("reset_valid", 32'(valid_o), 0);
        check("reset_busy", 32'(busy_o), 0);
        check("reset_ovf", 32'(overflow_o), 0);

        // Pulses on E1, E3, E5 of a 10-edge window.
        gate_len_i = 8'd10; start_i = 1'b1; tick(); start_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            pulse_i = (k == 1 || k == 3 || k == 5);
            tick();
            check("busy_in_window", 32'(busy_o), 1);
        end
        pulse_i = 1'b0;
        check("w10_valid", 32'(valid_o), 1);
        check("w10_count", 32'(count_o), 3);
        check("w10_ovf", 32'(overflow_o), 0);
        do_ack();
        check("ack_valid", 32'(valid_o), 0);
        check("ack_busy", 32'(busy_o), 0);
        check("ack_keep_count", 32'(count_o), 3);

        // Pulse at E0 is excluded, E4 included, E5 falls in DONE.
        gate_len_i = 8'd4; start_i = 1'b1; pulse_i = 1'b1; tick();
        start_i = 1'b0; pulse_i = 1'b0;
        tick(); tick(); tick();
        pulse_i = 1'b1; tick();
        tick();
        pulse_i = 1'b0;
        check("w4_count", 32'(count_o), 1);
        check("w4_valid", 32'(valid_o), 1);
        do_ack();

        // Saturation, then a clean window clears overflow.
        gate_len_i = 8'd30; start_i = 1'b1; tick(); start_i = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            pulse_i = (k <= 20);
            tick();
        end
        pulse_i = 1'b0;
        check("sat_count", 32'(count_o), 15);
        check("sat_ovf", 32'(overflow_o), 1);
        do_ack();
        gate_len_i = 8'd5; start_i = 1'b1; tick(); start_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            pulse_i = (k == 2 || k == 4);
            tick();
        end
        pulse_i = 1'b0;
        check("after_sat_count", 32'(count_o), 2);
        check("after_sat_ovf", 32'(overflow_o), 0);
        do_ack();

        // Zero-length window; start together with ack is dropped.
        gate_len_i = 8'd0; start_i = 1'b1; tick(); start_i = 1'b0;
        check("zero_valid", 32'(valid_o), 1);
        check("zero_count", 32'(count_o), 0);
        check("zero_busy", 32'(busy_o), 1);
        gate_len_i = 8'd6; start_i = 1'b1; ack_i = 1'b1; tick();
        start_i = 1'b0; ack_i = 1'b0;
        check("start_ack_busy", 32'(busy_o), 0);
        check("start_ack_valid", 32'(valid_o), 0);
        tick();
        check("start_ack_still_idle", 32'(busy_o), 0);

        // Abort keeps the previous result of 7.
        gate_len_i = 8'd7; start_i = 1'b1; tick(); start_i = 1'b0;
        pulse_i = 1'b1;
        for (int k = 1; k <= 7; k++) tick();
        pulse_i = 1'b0;
        check("prior_count", 32'(count_o), 7);
        do_ack();
        gate_len_i = 8'd20; start_i = 1'b1; tick(); start_i = 1'b0;
        pulse_i = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        pulse_i = 1'b0; abort_i = 1'b1; tick(); abort_i = 1'b0;
        check("abort_valid", 32'(valid_o), 0);
        check("abort_busy", 32'(busy_o), 0);
        check("abort_keep_count", 32'(count_o), 7);

        // Reset in the middle of a window after 5 pulses.
        gate_len_i = 8'd20; start_i = 1'b1; tick(); start_i = 1'b0;
        pulse_i = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        pulse_i = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
        check("midreset_count", 32'(count_o), 0);
        check("midreset_valid", 32'(valid_o), 0);
        check("midreset_busy", 32'(busy_o), 0);
        check("midreset_ovf", 32'(overflow_o), 0);

        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            start_i    = ($urandom_range(0, 3) == 0);
            gate_len_i = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            pulse_i    = 1'($urandom_range(0, 1));
            abort_i    = ($urandom_range(0, 49) == 0);
            ack_i      = ($urandom_range(0, 7) == 0);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_freq_counter.md
EDGE_FREQ_COUNTER -- requirements
Module: edge_freq_counter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of the pulse count and result.
REQ-002 SHALL have parameter GATE_WIDTH, default 32, width of the gate-length operand.
REQ-003 SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pulse_i  input  1  single-cycle event pulse from the upstream synchronizer/edge detector, already in the clock domain.
REQ-006 SHALL have port gate_len_i  input  GATE_WIDTH  measurement window length in clock cycles, sampled with start_i.
REQ-007 SHALL have port start_i  input  1  begin a measurement; honoured only in IDLE.
REQ-008 SHALL have port abort_i  input  1  cancel a measurement in progress.
REQ-009 SHALL have port ack_i  input  1  consumer acknowledges the result.
REQ-010 SHALL have port count_o  output  CNT_WIDTH  pulses counted in the last completed window.
REQ-011 SHALL have port overflow_o  output  1  set when the last result saturated.
REQ-012 SHALL have port valid_o  output  1  result available, held until acknowledged.
REQ-013 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement three states: IDLE, COUNT, DONE; all outputs registered.
REQ-015 IDLE: start_i=1 at edge E0 SHALL load gate_len_i into a remaining-cycles counter, clear the pulse counter and the overflow flag, and enter COUNT (gate_len_i=0: enter DONE directly).
REQ-016 The window SHALL be the N=gate_len_i edges E1..EN; pulse_i sampled at E0 SHALL NOT count, and pulse_i sampled at EN SHALL count.
REQ-017 COUNT: each edge with pulse_i=1 SHALL increment the pulse counter by 1, saturating at 2^CNT_WIDTH-1; an increment attempted at saturation SHALL set the overflow flag, which is sticky for the window.
REQ-018 COUNT: at EN the block SHALL enter DONE, load count_o with the final count (including the EN pulse), load overflow_o, and set valid_o, all visible from the cycle after EN.
REQ-019 gate_len_i=0 SHALL yield count_o=0, overflow_o=0, valid_o=1 from the cycle after E0.
REQ-020 DONE: valid_o SHALL stay 1 and count_o/overflow_o SHALL stay stable until ack_i=1; on that edge the block SHALL return to IDLE and clear valid_o.
REQ-021 ack_i outside DONE SHALL be ignored.
REQ-022 start_i outside IDLE SHALL be ignored, including start_i together with ack_i in DONE; the start must be reissued in IDLE.
REQ-023 abort_i=1 in COUNT or DONE SHALL return to IDLE on that edge and clear valid_o, leaving count_o/overflow_o unchanged from the previous completed result.
REQ-024 abort_i SHALL take priority over ack_i and over window completion on the same edge.
REQ-025 count_o/overflow_o SHALL retain the last result after ack until the next completion.

Reset
REQ-026 reset=1 at any edge SHALL force IDLE, with count_o=0, overflow_o=0, valid_o=0, busy_o=0, and internal counters 0.
REQ-027 reset SHALL override start_i, abort_i, ack_i and pulse_i on the same edge, including when asserted mid-COUNT or in DONE.

Verification
REQ-028 gate_len=10, pulses at window edges E1, E3, E5 -> valid_o=1 after E10, count_o=3, overflow_o=0, busy_o=1 throughout E1..E10.
REQ-029 gate_len=4, pulse at E0 and at E4 -> count_o=1; pulse at E5 (in DONE) is not counted.
REQ-030 CNT_WIDTH=4, gate_len=30, 20 pulses -> count_o=15, overflow_o=1; next window with 2 pulses -> count_o=2, overflow_o=0.
REQ-031 gate_len=0 with start -> valid_o=1 the next cycle, count_o=0; start+ack together in DONE -> IDLE with no new window (busy_o=0).
REQ-032 Mid-COUNT reset after 5 pulses -> all outputs 0 the next cycle; separately, abort mid-COUNT after a prior result of 7 -> IDLE, valid_o=0, count_o stays 7.
